// File: rtl/dk_sound_mix.sv
// ---------------------------------------------------------------------------
// dk_sound_mix
//
// Mixes NUM_CH signed 16-bit discrete-sound voices into one signed 16-bit
// sample per audio tick. On each audio_clk_en the voice samples and their
// unsigned Q1.7 gains are captured. One multiplier then walks the channels,
// one channel per clock. The sum is scaled back by 2^7 and saturated.
//
// Optional DC blocker: define DK_SOUND_MIX_DCBLOCK_EN to insert a one-pole
// DC-blocking stage after saturation. This adds one cycle of latency.
//
// Ports:
//   clk           system clock (shared with the voice blocks)
//   rst_n         asynchronous active-low reset
//   audio_clk_en  one-cycle sample strobe
//   ch_in         packed signed voices, channel k at [16k+15:16k]
//   ch_gain       packed unsigned Q1.7 gains, channel k at [GAIN_W*k +: GAIN_W]
//   mix_out       signed mixed sample, held between updates
//   mix_valid     one-cycle pulse when mix_out updates
//   overrun       sticky: a strobe arrived while a mix was in progress
// ---------------------------------------------------------------------------
module dk_sound_mix #(
  parameter int NUM_CH   = 4,
  parameter int GAIN_W   = 8,
  parameter int DC_SHIFT = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     audio_clk_en,
  input  logic [NUM_CH*16-1:0]     ch_in,
  input  logic [NUM_CH*GAIN_W-1:0] ch_gain,
  output logic signed [15:0]       mix_out,
  output logic                     mix_valid,
  output logic                     overrun
);

  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PROD_W = 16 + GAIN_W + 1;
  // The clog2 headroom bits guarantee that the accumulator cannot wrap.
  localparam int ACC_W  = PROD_W + $clog2(NUM_CH);

  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_CH - 1);
  localparam logic signed [ACC_W-1:0] ACC_MAX  = ACC_W'(32'sd32767);
  localparam logic signed [ACC_W-1:0] ACC_MIN  = ACC_W'(-32'sd32768);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    SAT  = 2'd2
`ifdef DK_SOUND_MIX_DCBLOCK_EN
    ,
    DCB  = 2'd3
`endif
  } state_t;

  // Clamp the scaled accumulator into the signed 16-bit range.
  function automatic logic signed [15:0] sat_acc(input logic signed [ACC_W-1:0] v);
    logic signed [15:0] r;
    if (v > ACC_MAX) begin
      r = 16'sh7FFF;
    end else if (v < ACC_MIN) begin
      r = 16'sh8000;
    end else begin
      r = v[15:0];
    end
    return r;
  endfunction

`ifdef DK_SOUND_MIX_DCBLOCK_EN
  // Clamp the 18-bit DC-blocker output into the signed 16-bit range.
  function automatic logic signed [15:0] sat_y(input logic signed [17:0] v);
    logic signed [15:0] r;
    if (v > 18'sd32767) begin
      r = 16'sh7FFF;
    end else if (v < -18'sd32768) begin
      r = 16'sh8000;
    end else begin
      r = v[15:0];
    end
    return r;
  endfunction
`endif

  state_t                    state_r;
  state_t                    state_nx_s;
  logic [IDX_W-1:0]          idx_r;
  logic signed [ACC_W-1:0]   acc_r;
  logic [NUM_CH*16-1:0]      ch_snap_r;
  logic [NUM_CH*GAIN_W-1:0]  gain_snap_r;

  logic signed [15:0]        ch_arr_s   [NUM_CH];
  logic [GAIN_W-1:0]         gain_arr_s [NUM_CH];
  logic signed [15:0]        sample_s;
  logic signed [GAIN_W:0]    gain_ext_s;
  logic signed [PROD_W-1:0]  prod_s;
  logic signed [ACC_W-1:0]   acc_sum_s;
  logic signed [ACC_W-1:0]   scaled_s;
  logic                      last_s;

`ifdef DK_SOUND_MIX_DCBLOCK_EN
  logic signed [15:0]        s_r;
  logic signed [15:0]        s_prev_r;
  logic signed [17:0]        y_prev_r;
  logic signed [17:0]        y_shr_s;
  logic signed [18:0]        y_wide_s;
  logic signed [17:0]        y_s;
`endif

  // Slice the snapshot words into per-channel arrays for the MAC mux.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign ch_arr_s[g]   = ch_snap_r[16*g +: 16];
    assign gain_arr_s[g] = gain_snap_r[GAIN_W*g +: GAIN_W];
  end

  assign sample_s   = ch_arr_s[idx_r];
  // The gain is unsigned. A zero is prepended so the signed multiply treats it as positive.
  assign gain_ext_s = {1'b0, gain_arr_s[idx_r]};
  assign prod_s     = PROD_W'(sample_s) * PROD_W'(gain_ext_s);
  assign acc_sum_s  = acc_r + ACC_W'(prod_s);
  // The arithmetic shift floors toward minus infinity, which undoes the Q1.7 gain scale.
  assign scaled_s   = acc_sum_s >>> 3'd7;
  assign last_s     = (idx_r == LAST_IDX);

`ifdef DK_SOUND_MIX_DCBLOCK_EN
  // One-pole DC blocker: y = s - s_prev + y_prev - y_prev/2^DC_SHIFT.
  assign y_shr_s  = y_prev_r >>> DC_SHIFT;
  assign y_wide_s = 19'(s_r) - 19'(s_prev_r) + 19'(y_prev_r) - 19'(y_shr_s);
  assign y_s      = y_wide_s[17:0];
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (audio_clk_en) begin
          state_nx_s = MAC;
        end else begin
          state_nx_s = IDLE;
        end
      end
      MAC: begin
        if (last_s) begin
          state_nx_s = SAT;
        end else begin
          state_nx_s = MAC;
        end
      end
`ifdef DK_SOUND_MIX_DCBLOCK_EN
      SAT:     state_nx_s = DCB;
      DCB:     state_nx_s = IDLE;
`else
      SAT:     state_nx_s = IDLE;
`endif
      default: state_nx_s = IDLE;
    endcase
  end

  // Datapath: snapshot, multiply-accumulate, saturation and output registers.
  // The saturated result is registered on the final MAC edge. This makes
  // mix_out and mix_valid appear together in the SAT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r       <= '0;
      acc_r       <= '0;
      ch_snap_r   <= '0;
      gain_snap_r <= '0;
      mix_out     <= 16'sd0;
      mix_valid   <= 1'b0;
      overrun     <= 1'b0;
`ifdef DK_SOUND_MIX_DCBLOCK_EN
      s_r         <= 16'sd0;
      s_prev_r    <= 16'sd0;
      y_prev_r    <= 18'sd0;
`endif
    end else begin
      mix_valid <= 1'b0;
      // Any strobe outside IDLE is dropped. The drop is recorded here.
      if (audio_clk_en && (state_r != IDLE)) begin
        overrun <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (audio_clk_en) begin
            ch_snap_r   <= ch_in;
            gain_snap_r <= ch_gain;
            acc_r       <= '0;
            idx_r       <= '0;
          end
        end
        MAC: begin
          acc_r <= acc_sum_s;
          if (last_s) begin
            idx_r <= '0;
`ifdef DK_SOUND_MIX_DCBLOCK_EN
            s_r <= sat_acc(scaled_s);
`else
            mix_out   <= sat_acc(scaled_s);
            mix_valid <= 1'b1;
`endif
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        SAT: begin
`ifdef DK_SOUND_MIX_DCBLOCK_EN
          // The filter result and its history commit together when entering DCB.
          mix_out   <= sat_y(y_s);
          mix_valid <= 1'b1;
          s_prev_r  <= s_r;
          y_prev_r  <= y_s;
`endif
        end
`ifdef DK_SOUND_MIX_DCBLOCK_EN
        DCB: begin
        end
`endif
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dk_sound_mix.sv
module tb_dk_sound_mix;
  localparam int NUM_CH   = 4;
  localparam int GAIN_W   = 8;
  localparam int DC_SHIFT = 8;
`ifdef DK_SOUND_MIX_DCBLOCK_EN
  localparam int LAT = NUM_CH + 2;
`else
  localparam int LAT = NUM_CH + 1;
`endif

  logic                     clk          = 1'b0;
  logic                     rst_n        = 1'b0;
  logic                     audio_clk_en = 1'b0;
  logic [NUM_CH*16-1:0]     ch_in        = '0;
  logic [NUM_CH*GAIN_W-1:0] ch_gain      = '0;
  logic [15:0]              mix_out;
  logic                     mix_valid;
  logic                     overrun;

  int total = 0;
  int bad   = 0;

  // reference model state
  int   cnt       = 0;
  int   pend      = 0;
  int   exp_out   = 0;
  logic exp_valid = 1'b0;
  logic exp_ovr   = 1'b0;
  int   s_prev    = 0;
  int   y_prev    = 0;
  int   m_s;
  int   m_y;
  logic signed [17:0] m_y18;

  always #5 clk = ~clk;

  dk_sound_mix #(.NUM_CH(NUM_CH), .GAIN_W(GAIN_W), .DC_SHIFT(DC_SHIFT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .audio_clk_en (audio_clk_en),
    .ch_in        (ch_in),
    .ch_gain      (ch_gain),
    .mix_out      (mix_out),
    .mix_valid    (mix_valid),
    .overrun      (overrun)
  );

  function automatic logic [63:0] pack_ch(input int a, input int b, input int c, input int d);
    return {d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  function automatic logic [31:0] pack_g(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  function automatic int clamp16(input longint v);
    if (v > 32767) return 32767;
    else if (v < -32768) return -32768;
    else return int'(v);
  endfunction

  // mixed sample = clamp(floor(sum(ch*gain) / 128))
  function automatic int mix_of(input logic [63:0] c, input logic [31:0] g);
    longint sum;
    int sv;
    int gv;
    sum = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      sv  = $signed(c[16*k +: 16]);
      gv  = int'(g[8*k +: 8]);
      sum = sum + longint'(sv) * longint'(gv);
    end
    sum = sum >>> 7;
    return clamp16(sum);
  endfunction

  // Behavioural model: busy for LAT cycles after an accepted strobe, output on the last one.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt = 0; pend = 0; exp_out = 0; exp_valid = 1'b0; exp_ovr = 1'b0;
      s_prev = 0; y_prev = 0;
    end else begin
      exp_valid = 1'b0;
      if (cnt > 0) begin
        if (audio_clk_en) exp_ovr = 1'b1;
        cnt = cnt - 1;
        if (cnt == 1) begin
          exp_valid = 1'b1;
          exp_out   = pend;
        end
      end else if (audio_clk_en) begin
        m_s = mix_of(ch_in, ch_gain);
`ifdef DK_SOUND_MIX_DCBLOCK_EN
        m_y    = m_s - s_prev + y_prev - (y_prev >>> DC_SHIFT);
        m_y18  = 18'(m_y);
        s_prev = m_s;
        y_prev = int'(m_y18);
        pend   = clamp16(longint'(y_prev));
`else
        pend = m_s;
`endif
        cnt = LAT;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    total++;
    if (mix_valid !== exp_valid || int'($signed(mix_out)) != exp_out || overrun !== exp_ovr) begin
      bad++;
      $display("FAIL cycle_cmp t=%0t: got valid=%b out=%0d ovr=%b want valid=%b out=%0d ovr=%b",
               $time, mix_valid, $signed(mix_out), overrun, exp_valid, exp_out, exp_ovr);
    end
  end

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic run_sample(input string name, input logic [63:0] c, input logic [31:0] g,
                            input int want, input bit scramble, input bit dbl);
    int first;
    int pulses;
    int got;
    first = -1; pulses = 0; got = 0;
    @(negedge clk);
    ch_in = c; ch_gain = g; audio_clk_en = 1'b1;
    for (int k = 1; k <= LAT + 6; k++) begin
      @(negedge clk);
      audio_clk_en = (dbl && k == 2);
      if (scramble && k == 1) begin
        ch_in   = ~c;
        ch_gain = ~g;
      end
      if (mix_valid) begin
        pulses++;
        if (first < 0) begin
          first = k;
          got   = $signed(mix_out);
        end
      end
    end
    check({name, "_lat"}, first, LAT);
    check({name, "_pulses"}, pulses, 1);
    check(name, got, want);
    check({name, "_model"}, exp_out, want);
    if (dbl) check({name, "_ovr"}, int'(overrun), 1);
  endtask

  initial begin
    int pulses;
    // reset held while the strobe toggles
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      audio_clk_en = k[0];
      ch_in = pack_ch(1000, 2000, 3000, 4000);
      ch_gain = pack_g(128, 128, 128, 128);
      check("rst_out", int'($signed(mix_out)), 0);
      check("rst_valid", int'(mix_valid), 0);
      check("rst_ovr", int'(overrun), 0);
    end
    @(negedge clk);
    audio_clk_en = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;

`ifdef DK_SOUND_MIX_DCBLOCK_EN
    run_sample("dc1", pack_ch(1000, 0, 0, 0), pack_g(128, 0, 0, 0), 1000, 1'b0, 1'b0);
    run_sample("dc2", pack_ch(1000, 0, 0, 0), pack_g(128, 0, 0, 0), 997, 1'b0, 1'b0);
    run_sample("dc3", pack_ch(1000, 0, 0, 0), pack_g(128, 0, 0, 0), 994, 1'b0, 1'b0);
`endif

    // reset in the second MAC cycle aborts the sample
    pulses = 0;
    @(negedge clk);
    ch_in = pack_ch(1000, 1000, 1000, 1000);
    ch_gain = pack_g(128, 128, 128, 128);
    audio_clk_en = 1'b1;
    @(negedge clk);
    audio_clk_en = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (mix_valid) pulses++;
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < LAT + 4; k++) begin
      @(negedge clk);
      if (mix_valid) pulses++;
    end
    check("midrst_pulses", pulses, 0);
    check("midrst_out", int'($signed(mix_out)), 0);
    check("midrst_ovr", int'(overrun), 0);

`ifndef DK_SOUND_MIX_DCBLOCK_EN
    run_sample("unity_pos", pack_ch(1000, 0, 0, 0), pack_g(128, 0, 0, 0), 1000, 1'b0, 1'b0);
    run_sample("unity_neg", pack_ch(-1000, 0, 0, 0), pack_g(128, 0, 0, 0), -1000, 1'b0, 1'b0);
    run_sample("floor_neg", pack_ch(-1, 0, 0, 0), pack_g(64, 0, 0, 0), -1, 1'b0, 1'b0);
    run_sample("sat_pos", pack_ch(10000, 10000, 10000, 10000), pack_g(128, 128, 128, 128), 32767, 1'b0, 1'b0);
    run_sample("sat_neg", pack_ch(-20000, -20000, -20000, -20000), pack_g(128, 128, 128, 128), -32768, 1'b0, 1'b0);
    run_sample("gain_mix", pack_ch(2000, 3000, 0, 0), pack_g(64, 255, 0, 0), 6976, 1'b0, 1'b0);
    run_sample("gain_zero", pack_ch(5000, 7000, 0, 0), pack_g(0, 128, 0, 0), 7000, 1'b0, 1'b0);
    run_sample("snapshot", pack_ch(1234, -500, 0, 0), pack_g(128, 128, 0, 0), 734, 1'b1, 1'b0);
    run_sample("overrun", pack_ch(300, 0, 0, 0), pack_g(200, 0, 0, 0), 468, 1'b0, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
